// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared pipeline definitions for the hazard/flush controller:
//               FSM state encoding, register-field width and the $zero index.
// Revision    : 1.0  initial release
//==============================================================================
package hazard_ctrl_pkg;

    // Width of a register-file index field (rs/rt/rd)
    localparam int          REG_W    = 5;
    // Register 0 is hard-wired to zero, so it can never carry a hazard
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
//==============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
//               clr has priority over inc; count sticks at all-ones.
// Ports       : clk, rst (async, active-high), inc, clr -> count[WIDTH-1:0]
// Revision    : 1.0  initial release
//==============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = &r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : hazard_ctrl
// Description : Hazard and flush controller for a 5-stage MIPS pipeline.
//               Detects load-use hazards between ID and EX (single bubble),
//               sequences branch-taken flush windows of FLUSH_CYCLES cycles
//               and keeps saturating stall/flush cycle counters.
// Ports       : clk, rst (async, active-high)
//               id_rs/id_rt/id_use_rs/id_use_rt   : ID-stage operand usage
//               idex_mem_read/idex_rt             : load in EX and its dest
//               ex_branch_taken                   : branch resolved taken
//               cnt_clr                           : clear perf counters
//               pc_hold/ifid_hold/ifid_flush/idex_stall : combinational ctrl
//               flushing                          : registered FLUSH state
//               stall_cycles/flush_cycles         : saturating counters
// Revision    : 1.0  initial release
//==============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             ex_branch_taken,
    input  logic             cnt_clr,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             flushing,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    // Remaining FLUSH cycles after the branch cycle itself
    localparam logic [3:0] FCNT_INIT  = 4'(FLUSH_CYCLES - 1);
    localparam logic       MULTI_FLSH = (FLUSH_CYCLES > 1);

    hz_state_e   r_state;
    hz_state_e   w_state_nxt;
    logic [3:0]  r_fcnt;
    logic [3:0]  w_fcnt_nxt;

    logic        w_lu;
    logic        w_stall_inc;

    //--------------------------------------------------------------------------
    // Load-use detection: a load in EX writing a non-zero register that the
    // ID instruction actually reads.
    //--------------------------------------------------------------------------
    assign w_lu = idex_mem_read && (idex_rt != REG_ZERO) &&
                  ((id_use_rs && (id_rs == idex_rt)) ||
                   (id_use_rt && (id_rt == idex_rt)));

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and control outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        w_stall_inc = 1'b0;

        if (rst) begin
            // ID/EX has no reset of its own; keep loading bubbles into it
            idex_stall = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        // PC must be free to load the branch target
                        ifid_flush = 1'b1;
                        idex_stall = 1'b1;
                        if (MULTI_FLSH) begin
                            w_state_nxt = ST_FLUSH;
                            w_fcnt_nxt  = FCNT_INIT;
                        end
                    end else if (w_lu) begin
                        // One bubble; the bubble clears idex_mem_read so the
                        // hazard is not seen again next cycle
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_stall  = 1'b1;
                        w_stall_inc = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // EX holds only bubbles here, so hazards/branches are moot
                    ifid_flush = 1'b1;
                    idex_stall = 1'b1;
                    w_fcnt_nxt = r_fcnt - 4'd1;
                    if (r_fcnt == 4'd1) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                end
            endcase
        end
    end

    assign flushing = (r_state == ST_FLUSH);

    //--------------------------------------------------------------------------
    // Performance counters
    //--------------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .clr   (cnt_clr),
        .count (stall_cycles)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifid_flush),
        .clr   (cnt_clr),
        .count (flush_cycles)
    );

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl. Three instances
//               share one stimulus: A (FLUSH_CYCLES=3, CNT_W=4),
//               B (FLUSH_CYCLES=4, CNT_W=32), C (FLUSH_CYCLES=1, CNT_W=32).
// Revision    : 1.0  initial release
//==============================================================================
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rt;
    logic       id_use_rs, id_use_rt, idex_mem_read, ex_branch_taken, cnt_clr;

    logic        a_pc_hold, a_ifid_hold, a_ifid_flush, a_idex_stall, a_flushing;
    logic [3:0]  a_stall_cycles, a_flush_cycles;
    logic        b_pc_hold, b_ifid_hold, b_ifid_flush, b_idex_stall, b_flushing;
    logic [31:0] b_stall_cycles, b_flush_cycles;
    logic        c_pc_hold, c_ifid_hold, c_ifid_flush, c_idex_stall, c_flushing;
    logic [31:0] c_stall_cycles, c_flush_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .pc_hold(a_pc_hold), .ifid_hold(a_ifid_hold), .ifid_flush(a_ifid_flush),
        .idex_stall(a_idex_stall), .flushing(a_flushing),
        .stall_cycles(a_stall_cycles), .flush_cycles(a_flush_cycles)
    );

    hazard_ctrl #(.FLUSH_CYCLES(4), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .pc_hold(b_pc_hold), .ifid_hold(b_ifid_hold), .ifid_flush(b_ifid_flush),
        .idex_stall(b_idex_stall), .flushing(b_flushing),
        .stall_cycles(b_stall_cycles), .flush_cycles(b_flush_cycles)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(32)) u_dut_c (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .pc_hold(c_pc_hold), .ifid_hold(c_ifid_hold), .ifid_flush(c_ifid_flush),
        .idex_stall(c_idex_stall), .flushing(c_flushing),
        .stall_cycles(c_stall_cycles), .flush_cycles(c_flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        idex_mem_read = 1'b0; idex_rt = 5'd0; ex_branch_taken = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic set_lu();
        idex_mem_read = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    endtask

    int a_fl, a_fg, b_fl, b_fg, c_fl;

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        // Reset state
        check("rst_idex_stall_a", {31'd0, a_idex_stall}, 32'd1);
        check("rst_pc_hold_a",    {31'd0, a_pc_hold},    32'd0);
        check("rst_ifid_flush_a", {31'd0, a_ifid_flush}, 32'd0);
        check("rst_flushing_a",   {31'd0, a_flushing},   32'd0);
        check("rst_stall_cnt_a",  {28'd0, a_stall_cycles}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_idex_stall_a", {31'd0, a_idex_stall}, 32'd0);

        // Load-use detection
        set_lu();
        #1;
        check("lu_pc_hold",    {31'd0, a_pc_hold},    32'd1);
        check("lu_ifid_hold",  {31'd0, a_ifid_hold},  32'd1);
        check("lu_idex_stall", {31'd0, a_idex_stall}, 32'd1);
        check("lu_ifid_flush", {31'd0, a_ifid_flush}, 32'd0);
        tick();
        idex_mem_read = 1'b0;   // bubble now in EX
        #1;
        check("bubble_pc_hold",    {31'd0, a_pc_hold},    32'd0);
        check("bubble_idex_stall", {31'd0, a_idex_stall}, 32'd0);
        check("lu_stall_cnt_a",    {28'd0, a_stall_cycles}, 32'd1);
        check("lu_stall_cnt_c",    c_stall_cycles,          32'd1);

        // $zero exemption
        idle_inputs();
        idex_mem_read = 1'b1; idex_rt = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
        #1;
        check("zero_pc_hold",    {31'd0, a_pc_hold},    32'd0);
        check("zero_ifid_hold",  {31'd0, a_ifid_hold},  32'd0);
        check("zero_idex_stall", {31'd0, a_idex_stall}, 32'd0);
        tick();
        check("zero_stall_cnt_a", {28'd0, a_stall_cycles}, 32'd1);

        // rt match with use_rt, rs not used
        idle_inputs();
        idex_mem_read = 1'b1; idex_rt = 5'd17; id_rt = 5'd17; id_use_rt = 1'b1; id_rs = 5'd17;
        #1;
        check("lu_rt_idex_stall", {31'd0, a_idex_stall}, 32'd1);
        id_use_rt = 1'b0;       // register matches but not read
        #1;
        check("nouse_idex_stall", {31'd0, a_idex_stall}, 32'd0);
        idle_inputs();

        // Branch vs load-use priority, and multi-cycle flush windows
        set_lu();
        ex_branch_taken = 1'b1;
        #1;
        check("prio_ifid_flush_c", {31'd0, c_ifid_flush}, 32'd1);
        check("prio_idex_stall_c", {31'd0, c_idex_stall}, 32'd1);
        check("prio_pc_hold_c",    {31'd0, c_pc_hold},    32'd0);
        check("prio_ifid_hold_c",  {31'd0, c_ifid_hold},  32'd0);
        check("prio_pc_hold_a",    {31'd0, a_pc_hold},    32'd0);
        a_fl = int'(a_ifid_flush); a_fg = int'(a_flushing);
        b_fl = int'(b_ifid_flush); b_fg = int'(b_flushing);
        c_fl = int'(c_ifid_flush);
        tick();
        idle_inputs();
        #1;
        check("prio_stall_cnt_a", {28'd0, a_stall_cycles}, 32'd1);
        check("prio_stall_cnt_c", c_stall_cycles,          32'd1);
        check("flush_hold_excl_a", {31'd0, a_ifid_hold & a_ifid_flush}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            a_fl += int'(a_ifid_flush); a_fg += int'(a_flushing);
            b_fl += int'(b_ifid_flush); b_fg += int'(b_flushing);
            c_fl += int'(c_ifid_flush);
            tick();
        end
        check("win_flush_len_a",    a_fl, 32'd3);
        check("win_flushing_len_a", a_fg, 32'd2);
        check("win_flush_len_b",    b_fl, 32'd4);
        check("win_flushing_len_b", b_fg, 32'd3);
        check("win_flush_len_c",    c_fl, 32'd1);
        check("flush_cnt_a", {28'd0, a_flush_cycles}, 32'd3);
        check("flush_cnt_b", b_flush_cycles,          32'd4);
        check("flush_cnt_c", c_flush_cycles,          32'd1);
        check("end_flushing_a", {31'd0, a_flushing}, 32'd0);

        // Reset mid-flush on B's 2nd flush cycle
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        #1;
        check("mid_flushing_b", {31'd0, b_flushing}, 32'd1);
        rst = 1'b1;
        #1;
        check("mrst_flushing_b",   {31'd0, b_flushing},   32'd0);
        check("mrst_idex_stall_b", {31'd0, b_idex_stall}, 32'd1);
        check("mrst_ifid_flush_b", {31'd0, b_ifid_flush}, 32'd0);
        check("mrst_flush_cnt_b",  b_flush_cycles,        32'd0);
        check("mrst_stall_cnt_b",  b_stall_cycles,        32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mrel_idex_stall_b", {31'd0, b_idex_stall}, 32'd0);
        check("mrel_ifid_flush_b", {31'd0, b_ifid_flush}, 32'd0);
        tick();
        check("mrel_flushing_b",   {31'd0, b_flushing},   32'd0);
        check("mrel_flush_cnt_b",  b_flush_cycles,        32'd0);

        // Counter saturation then clear-with-stall
        set_lu();
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall_cnt_a", {28'd0, a_stall_cycles}, 32'd15);
        check("sat_stall_cnt_b", b_stall_cycles,          32'd20);
        cnt_clr = 1'b1;
        tick();
        check("clr_stall_cnt_a", {28'd0, a_stall_cycles}, 32'd0);
        check("clr_stall_cnt_b", b_stall_cycles,          32'd0);
        cnt_clr = 1'b0;
        tick();
        check("post_clr_cnt_b", b_stall_cycles, 32'd1);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
